// File: rtl/qpl_req_arbiter.sv
// Arbitrates REQS requesters onto the QPL manager alloc/dealloc streams and steers in-order
// replies back through a per-stream tag FIFO. Define QPL_ARB_FIXED_PRIO_EN for fixed priority.
module qpl_req_arbiter #(
  parameter int unsigned REQS  = 4,
  parameter int unsigned REQ_W = 18,
  parameter int unsigned REP_W = 15,
  parameter int unsigned OUTS  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,

  input  logic [REQS-1:0]              i_req_alloc_vld,
  input  logic [REQS-1:0][REQ_W-1:0]   i_req_alloc_data,
  output logic [REQS-1:0]              o_req_alloc_rdy,
  output logic                         o_mreq_alloc_vld,
  output logic [REQ_W-1:0]             o_mreq_alloc_data,
  input  logic                         i_mreq_alloc_rdy,
  input  logic                         i_mrep_alloc_vld,
  input  logic [REP_W-1:0]             i_mrep_alloc_data,
  output logic                         o_mrep_alloc_rdy,
  output logic [REQS-1:0]              o_rep_alloc_vld,
  output logic [REP_W-1:0]             o_rep_alloc_data,
  input  logic [REQS-1:0]              i_rep_alloc_rdy,
  output logic [$clog2(OUTS):0]        o_alloc_pend,

  input  logic [REQS-1:0]              i_req_dealloc_vld,
  input  logic [REQS-1:0][REP_W-1:0]   i_req_dealloc_data,
  output logic [REQS-1:0]              o_req_dealloc_rdy,
  output logic                         o_mreq_dealloc_vld,
  output logic [REP_W-1:0]             o_mreq_dealloc_data,
  input  logic                         i_mreq_dealloc_rdy,
  input  logic                         i_mrep_dealloc_vld,
  input  logic [REP_W-1:0]             i_mrep_dealloc_data,
  output logic                         o_mrep_dealloc_rdy,
  output logic [REQS-1:0]              o_rep_dealloc_vld,
  output logic [REP_W-1:0]             o_rep_dealloc_data,
  input  logic [REQS-1:0]              i_rep_dealloc_rdy,
  output logic [$clog2(OUTS):0]        o_dealloc_pend,

  output logic                         o_orphan
);

  localparam int unsigned ID_W   = $clog2(REQS);
  localparam int unsigned AW     = $clog2(OUTS);
  localparam int unsigned PEND_W = AW + 1;

  logic [1:0] orphan_set;
  logic       orphan_q;

  // Stream 0 is alloc, stream 1 is dealloc; only the payload width differs.
  for (genvar s = 0; s < 2; s++) begin : g_stream
    localparam int unsigned DW = (s == 0) ? REQ_W : REP_W;

    logic [REQS-1:0]         req_vld;
    logic [REQS-1:0][DW-1:0] req_data;
    logic [REQS-1:0]         req_rdy;
    logic                    mreq_rdy;
    logic                    mrep_vld;
    logic                    mrep_rdy;
    logic [REQS-1:0]         rep_vld;
    logic [REQS-1:0]         rep_rdy;

    logic                    mreq_vld_q;
    logic [DW-1:0]           mreq_data_q;

    logic [ID_W-1:0]         tag_mem [OUTS];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [PEND_W-1:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]         head;
    logic                    full, empty;

    logic                    stage_free;
    logic                    found;
    logic [ID_W-1:0]         win;
    logic                    grant;
    logic                    push, pop;

    if (s == 0) begin : g_alloc
      assign req_vld           = i_req_alloc_vld;
      assign req_data          = i_req_alloc_data;
      assign o_req_alloc_rdy   = req_rdy;
      assign o_mreq_alloc_vld  = mreq_vld_q;
      assign o_mreq_alloc_data = mreq_data_q;
      assign mreq_rdy          = i_mreq_alloc_rdy;
      assign mrep_vld          = i_mrep_alloc_vld;
      assign o_mrep_alloc_rdy  = mrep_rdy;
      assign o_rep_alloc_vld   = rep_vld;
      assign o_rep_alloc_data  = i_mrep_alloc_data;
      assign rep_rdy           = i_rep_alloc_rdy;
      assign o_alloc_pend      = cnt_q;
    end else begin : g_dealloc
      assign req_vld             = i_req_dealloc_vld;
      assign req_data            = i_req_dealloc_data;
      assign o_req_dealloc_rdy   = req_rdy;
      assign o_mreq_dealloc_vld  = mreq_vld_q;
      assign o_mreq_dealloc_data = mreq_data_q;
      assign mreq_rdy            = i_mreq_dealloc_rdy;
      assign mrep_vld            = i_mrep_dealloc_vld;
      assign o_mrep_dealloc_rdy  = mrep_rdy;
      assign o_rep_dealloc_vld   = rep_vld;
      assign o_rep_dealloc_data  = i_mrep_dealloc_data;
      assign rep_rdy             = i_rep_dealloc_rdy;
      assign o_dealloc_pend      = cnt_q;
    end

    assign full       = (cnt_q == PEND_W'(OUTS));
    assign empty      = (cnt_q == '0);
    assign head       = tag_mem[rd_ptr_q];
    assign stage_free = !mreq_vld_q || mreq_rdy;

`ifndef QPL_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] ptr_q;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        ptr_q <= '0;
      end else if (grant) begin
        ptr_q <= (win == ID_W'(REQS - 1)) ? '0 : win + 1'b1;
      end
    end
`endif

    // First valid requester scanning upward (with wrap) from the round-robin pointer.
    always_comb begin : p_arb
      logic [ID_W-1:0] idx;
      idx   = '0;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < int'(REQS); i++) begin
`ifdef QPL_ARB_FIXED_PRIO_EN
        idx = ID_W'(i);
`else
        idx = ID_W'((int'(ptr_q) + i) % int'(REQS));
`endif
        if (!found && req_vld[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end

    assign grant   = stage_free && !full && found;
    assign req_rdy = grant ? (REQS'(1) << win) : '0;
    assign push    = grant;

    assign rep_vld  = (mrep_vld && !empty) ? (REQS'(1) << head) : '0;
    assign mrep_rdy = !empty && rep_rdy[head];
    assign pop      = mrep_vld && mrep_rdy;

    assign orphan_set[s] = mrep_vld && empty;

    always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        mreq_vld_q  <= 1'b0;
        mreq_data_q <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        cnt_q       <= '0;
      end else begin
        if (grant) begin
          mreq_vld_q  <= 1'b1;
          mreq_data_q <= req_data[win];
        end else if (stage_free) begin
          mreq_vld_q  <= 1'b0;
        end
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q <= cnt_d;
      end
    end

    // Tag storage needs no reset: entries are only read while the FIFO is non-empty.
    always_ff @(posedge i_clk) begin
      if (push) tag_mem[wr_ptr_q] <= win;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      orphan_q <= 1'b0;
    end else if (|orphan_set) begin
      orphan_q <= 1'b1;
    end
  end

  assign o_orphan = orphan_q;

endmodule

// File: tb/tb_qpl_req_arbiter.sv
// Directed self-checking bench for qpl_req_arbiter (REQS=4, REQ_W=18, REP_W=15, OUTS=8).
module tb_qpl_req_arbiter;
  localparam int unsigned REQS  = 4;
  localparam int unsigned REQ_W = 18;
  localparam int unsigned REP_W = 15;
  localparam int unsigned OUTS  = 8;

  localparam logic [3:0][17:0] AD = {18'h00FF3, 18'h3C3C2, 18'h15A31, 18'h2A5C0};
  localparam logic [3:0][14:0] DD = {15'h4321, 15'h1357, 15'h7ACE, 15'h0F0F};

`ifdef QPL_ARB_FIXED_PRIO_EN
  int t1_win[5]     = '{0, 0, 0, 0, 0};
  int drain_head[8] = '{0, 0, 0, 0, 2, 3, 3, 3};
  int pr_win[4]     = '{1, 1, 1, 1};
`else
  int t1_win[5]     = '{0, 1, 2, 3, 0};
  int drain_head[8] = '{1, 2, 3, 0, 2, 3, 3, 3};
  int pr_win[4]     = '{1, 3, 1, 3};
`endif

  logic clk = 1'b0;
  logic rst;

  logic [3:0]       a_vld, a_rdy, arep_vld, arep_rdy;
  logic [3:0][17:0] a_data;
  logic             am_vld, am_rdy, ar_vld, ar_rdy;
  logic [17:0]      am_data;
  logic [14:0]      ar_data, arep_data;
  logic [3:0]       a_pend;

  logic [3:0]       d_vld, d_rdy, drep_vld, drep_rdy;
  logic [3:0][14:0] d_data;
  logic             dm_vld, dm_rdy, dr_vld, dr_rdy;
  logic [14:0]      dm_data, dr_data, drep_data;
  logic [3:0]       d_pend;

  logic             orphan;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qpl_req_arbiter #(
    .REQS (REQS),
    .REQ_W(REQ_W),
    .REP_W(REP_W),
    .OUTS (OUTS)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_req_alloc_vld    (a_vld),
    .i_req_alloc_data   (a_data),
    .o_req_alloc_rdy    (a_rdy),
    .o_mreq_alloc_vld   (am_vld),
    .o_mreq_alloc_data  (am_data),
    .i_mreq_alloc_rdy   (am_rdy),
    .i_mrep_alloc_vld   (ar_vld),
    .i_mrep_alloc_data  (ar_data),
    .o_mrep_alloc_rdy   (ar_rdy),
    .o_rep_alloc_vld    (arep_vld),
    .o_rep_alloc_data   (arep_data),
    .i_rep_alloc_rdy    (arep_rdy),
    .o_alloc_pend       (a_pend),
    .i_req_dealloc_vld  (d_vld),
    .i_req_dealloc_data (d_data),
    .o_req_dealloc_rdy  (d_rdy),
    .o_mreq_dealloc_vld (dm_vld),
    .o_mreq_dealloc_data(dm_data),
    .i_mreq_dealloc_rdy (dm_rdy),
    .i_mrep_dealloc_vld (dr_vld),
    .i_mrep_dealloc_data(dr_data),
    .o_mrep_dealloc_rdy (dr_rdy),
    .o_rep_dealloc_vld  (drep_vld),
    .o_rep_dealloc_data (drep_data),
    .i_rep_dealloc_rdy  (drep_rdy),
    .o_dealloc_pend     (d_pend),
    .o_orphan           (orphan)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " am_vld"},   32'(am_vld),   32'd0);
    chk({tag, " am_data"},  32'(am_data),  32'd0);
    chk({tag, " a_pend"},   32'(a_pend),   32'd0);
    chk({tag, " dm_vld"},   32'(dm_vld),   32'd0);
    chk({tag, " dm_data"},  32'(dm_data),  32'd0);
    chk({tag, " d_pend"},   32'(d_pend),   32'd0);
    chk({tag, " orphan"},   32'(orphan),   32'd0);
    chk({tag, " arep_vld"}, 32'(arep_vld), 32'd0);
    chk({tag, " ar_rdy"},   32'(ar_rdy),   32'd0);
    chk({tag, " drep_vld"}, 32'(drep_vld), 32'd0);
    chk({tag, " dr_rdy"},   32'(dr_rdy),   32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_vld = '0; a_data = AD; am_rdy = 1'b0; ar_vld = 1'b0; ar_data = '0; arep_rdy = '0;
    d_vld = '0; d_data = DD; dm_rdy = 1'b0; dr_vld = 1'b0; dr_data = '0; drep_rdy = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");

    // All four requesters valid, manager always ready, no replies.
    a_vld  = 4'hF;
    am_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr a_rdy", 32'(a_rdy), 32'(4'b0001 << t1_win[k]));
      tick();
      chk("rr am_vld",  32'(am_vld),  32'd1);
      chk("rr am_data", 32'(am_data), 32'(AD[t1_win[k]]));
      chk("rr a_pend",  32'(a_pend),  32'(k + 1));
    end

    // Manager stalls for three cycles with one request registered.
    a_vld  = 4'b0100;
    am_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall a_rdy", 32'(a_rdy), 32'd0);
      tick();
      chk("stall am_data", 32'(am_data), 32'(AD[t1_win[4]]));
      chk("stall am_vld",  32'(am_vld),  32'd1);
      chk("stall a_pend",  32'(a_pend),  32'd5);
    end
    am_rdy = 1'b1;
    #1;
    chk("resume a_rdy", 32'(a_rdy), 32'b0100);
    tick();
    chk("resume am_data", 32'(am_data), 32'(AD[2]));
    chk("resume a_pend",  32'(a_pend),  32'd6);

    // Fill the tag FIFO to OUTS entries.
    a_vld = 4'b1000;
    #1;
    chk("fill a_rdy 7", 32'(a_rdy), 32'b1000);
    tick();
    chk("fill a_pend 7", 32'(a_pend),  32'd7);
    chk("fill am_data",  32'(am_data), 32'(AD[3]));
    chk("fill a_rdy 8",  32'(a_rdy),   32'b1000);
    tick();
    chk("full a_pend", 32'(a_pend), 32'd8);
    chk("full a_rdy",  32'(a_rdy),  32'd0);
    chk("full am_vld", 32'(am_vld), 32'd1);

    // Pop while full: the push stays blocked in that same cycle.
    ar_vld   = 1'b1;
    ar_data  = 15'h0A11;
    arep_rdy = 4'hF;
    #1;
    chk("popfull arep_vld",  32'(arep_vld),  32'b0001);
    chk("popfull ar_rdy",    32'(ar_rdy),    32'd1);
    chk("popfull arep_data", 32'(arep_data), 32'h0A11);
    chk("popfull a_rdy",     32'(a_rdy),     32'd0);
    tick();
    chk("popfull a_pend", 32'(a_pend), 32'd7);
    chk("drain am_vld",   32'(am_vld), 32'd0);
    ar_vld = 1'b0;
    #1;
    chk("regrant a_rdy", 32'(a_rdy), 32'b1000);
    tick();
    chk("regrant a_pend",  32'(a_pend),  32'd8);
    chk("regrant am_data", 32'(am_data), 32'(AD[3]));
    a_vld = '0;

    // Drain the eight outstanding tags in request order.
    for (int k = 0; k < 8; k++) begin
      ar_vld  = 1'b1;
      ar_data = 15'(k * 3 + 5);
      #1;
      chk("drain arep_vld",  32'(arep_vld),  32'(4'b0001 << drain_head[k]));
      chk("drain ar_rdy",    32'(ar_rdy),    32'd1);
      chk("drain arep_data", 32'(arep_data), 32'(k * 3 + 5));
      tick();
      chk("drain a_pend", 32'(a_pend), 32'(7 - k));
    end
    ar_vld = 1'b0;
    #1;
    chk("empty ar_rdy",   32'(ar_rdy),   32'd0);
    chk("empty arep_vld", 32'(arep_vld), 32'd0);
    chk("empty am_vld",   32'(am_vld),   32'd0);

    // Dealloc stream: requests from 2, 0, 3 then in-order replies.
    dm_rdy   = 1'b1;
    drep_rdy = 4'hF;
    d_vld    = 4'b0100;
    #1;
    chk("dq2 d_rdy", 32'(d_rdy), 32'b0100);
    tick();
    chk("dq2 dm_data", 32'(dm_data), 32'(DD[2]));
    d_vld = 4'b0001;
    #1;
    chk("dq0 d_rdy", 32'(d_rdy), 32'b0001);
    tick();
    chk("dq0 dm_data", 32'(dm_data), 32'(DD[0]));
    d_vld = 4'b1000;
    #1;
    chk("dq3 d_rdy", 32'(d_rdy), 32'b1000);
    tick();
    chk("dq3 dm_data", 32'(dm_data), 32'(DD[3]));
    chk("dq3 dm_vld",  32'(dm_vld),  32'd1);
    chk("dq3 d_pend",  32'(d_pend),  32'd3);
    d_vld = '0;

    dr_vld  = 1'b1;
    dr_data = 15'h0111;
    #1;
    chk("R0 drep_vld",  32'(drep_vld),  32'b0100);
    chk("R0 dr_rdy",    32'(dr_rdy),    32'd1);
    chk("R0 drep_data", 32'(drep_data), 32'h0111);
    tick();
    dr_data  = 15'h0222;
    drep_rdy = 4'b1110;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("R1 hold drep_vld", 32'(drep_vld), 32'b0001);
      chk("R1 hold dr_rdy",   32'(dr_rdy),   32'd0);
      tick();
      chk("R1 hold d_pend", 32'(d_pend), 32'd2);
    end
    drep_rdy = 4'hF;
    #1;
    chk("R1 dr_rdy", 32'(dr_rdy), 32'd1);
    tick();
    dr_data = 15'h0333;
    #1;
    chk("R2 drep_vld", 32'(drep_vld), 32'b1000);
    tick();
    chk("R2 d_pend", 32'(d_pend), 32'd0);
    dr_vld = 1'b0;
    #1;
    chk("dempty drep_vld", 32'(drep_vld), 32'd0);
    chk("dempty dr_rdy",   32'(dr_rdy),   32'd0);

    // Reply with nothing outstanding sets the sticky orphan flag.
    ar_vld = 1'b1;
    #1;
    chk("orphan ar_rdy",    32'(ar_rdy),   32'd0);
    chk("orphan arep_vld",  32'(arep_vld), 32'd0);
    chk("orphan pre",       32'(orphan),   32'd0);
    tick();
    chk("orphan set", 32'(orphan), 32'd1);
    ar_vld = 1'b0;
    tick();
    chk("orphan sticky", 32'(orphan), 32'd1);

    // Mid-operation reset discards the in-flight request and the pointer.
    a_vld = 4'b0001;
    tick();
    a_vld = '0;
    chk("inflight am_vld", 32'(am_vld), 32'd1);
    chk("inflight a_pend", 32'(a_pend), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rst2");
    a_vld = 4'hF;
    #1;
    chk("rst2 a_rdy", 32'(a_rdy), 32'b0001);

    // Requesters 1 and 3 continuously valid.
    a_vld = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("prio a_rdy", 32'(a_rdy), 32'(4'b0001 << pr_win[k]));
      tick();
      chk("prio am_data", 32'(am_data), 32'(AD[pr_win[k]]));
    end
    a_vld = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
